// File: rtl/write_back_ctrl.sv
// rtl/write_back_ctrl.sv - register-file write-back sequencer with muldiv/shift waits and SP init write
module write_back_ctrl #(
    parameter int SP_REG  = 29,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] wb_class,
    input  logic [4:0] rd_addr,
    input  logic       muldiv_busy,
    input  logic       shift_done,
    input  logic       abort,
    output logic [3:0] DataSrc,
    output logic [4:0] wr_addr,
    output logic       reg_write,
    output logic       ready,
    output logic       done,
    output logic       err
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [2:0] {INIT, IDLE, WAIT_MD, WAIT_SH, WRITE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    cls_q, cls_n, data_src_n, issue_cls;
    logic [4:0]    addr_q, addr_n, wr_addr_n, issue_addr;
    logic          reg_write_n, done_n, err_n, issue, cond;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cls_n       = cls_q;
        addr_n      = addr_q;
        data_src_n  = DataSrc;
        wr_addr_n   = wr_addr;
        reg_write_n = 1'b0;
        done_n      = 1'b0;
        err_n       = 1'b0;
        issue       = 1'b0;
        issue_cls   = cls_q;
        issue_addr  = addr_q;
        cond        = (state == WAIT_MD) ? !muldiv_busy : shift_done;
        cnt_inc     = (cnt == TMO) ? cnt : cnt + 1'b1;

        case (state)
            INIT: begin
                state_n     = WRITE;
                data_src_n  = 4'd7;
                wr_addr_n   = 5'(SP_REG);
                reg_write_n = 1'b1;
            end
            IDLE: begin
                if (!abort && start) begin
                    cls_n      = wb_class;
                    addr_n     = rd_addr;
                    cnt_n      = '0;
                    issue_cls  = wb_class;
                    issue_addr = rd_addr;
                    case (wb_class)
                        4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10: issue = 1'b1;
                        4'd2, 4'd3: begin
                            if (muldiv_busy) state_n = WAIT_MD;
                            else             issue   = 1'b1;
                        end
                        // a shift_done level seen at start belongs to the previous shift
                        4'd8:    state_n = WAIT_SH;
                        default: err_n   = 1'b1;
                    endcase
                end
            end
            WAIT_MD, WAIT_SH: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cond) begin
                    issue = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == TMO) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            WRITE:   state_n = IDLE;
            default: state_n = INIT;
        endcase

        if (issue) begin
            state_n     = WRITE;
            reg_write_n = 1'b1;
            done_n      = 1'b1;
            data_src_n  = issue_cls;
            wr_addr_n   = issue_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            cnt       <= '0;
            cls_q     <= '0;
            addr_q    <= '0;
            DataSrc   <= '0;
            wr_addr   <= '0;
            reg_write <= 1'b0;
            ready     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cls_q     <= cls_n;
            addr_q    <= addr_n;
            DataSrc   <= data_src_n;
            wr_addr   <= wr_addr_n;
            reg_write <= reg_write_n;
            ready     <= (state_n == IDLE);
            done      <= done_n;
            err       <= err_n;
        end
    end
endmodule
